// File: rtl/div_seq.sv
// Sequential signed restoring divider: 2*width-bit dividend / width-bit divisor.
// One quotient bit per clock; done pulses 2*width+1 edges after start is accepted.
module div_seq #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*width-1:0] dividend,
  input  logic [width-1:0]   divisor,
  output logic [width-1:0]   quotient,
  output logic [width-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int DW = 2 * width;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  // Largest quotient magnitudes representable for a positive / negative result.
  localparam logic [DW-1:0] QMAX_POS = {{(width + 1){1'b0}}, {(width - 1){1'b1}}};
  localparam logic [DW-1:0] QMAX_NEG = {{width{1'b0}}, 1'b1, {(width - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [width-1:0]  dvs_q, dvs_d;
  logic [width:0]    rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_dvd_q, sign_dvd_d;
  logic              sign_dvs_q, sign_dvs_d;
  logic              zero_q, zero_d;
  logic [width-1:0]  quo_q, quo_d;
  logic [width-1:0]  rmd_q, rmd_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     dvd_abs;
  logic [width-1:0]  dvs_abs;
  logic [width+1:0]  shifted;
  logic [width+1:0]  trial;
  logic              trial_ge;
  logic              neg_quo;
  logic              quo_ovf;

  // Unary minus on an unsigned vector yields the magnitude of the most-negative value too.
  assign dvd_abs  = dividend[DW-1] ? -dividend : dividend;
  assign dvs_abs  = divisor[width-1] ? -divisor : divisor;

  assign shifted  = {rem_q, dvd_q[DW-1]};
  assign trial    = shifted - {2'b00, dvs_q};
  assign trial_ge = ~trial[width+1];

  assign neg_quo  = sign_dvd_q ^ sign_dvs_q;
  assign quo_ovf  = neg_quo ? (dvd_q > QMAX_NEG) : (dvd_q > QMAX_POS);

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sign_dvd_d = sign_dvd_q;
    sign_dvs_d = sign_dvs_q;
    zero_d     = zero_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d      = dvd_abs;
          dvs_d      = dvs_abs;
          sign_dvd_d = dividend[DW-1];
          sign_dvs_d = divisor[width-1];
          zero_d     = (divisor == '0);
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = ST_CALC;
        end
      end

      ST_CALC: begin
        // Quotient bits fill the dividend register from the bottom as its top bits shift out.
        rem_d = trial_ge ? trial[width:0] : shifted[width:0];
        dvd_d = {dvd_q[DW-2:0], trial_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (zero_q) begin
          quo_d = '0;
          rmd_d = '0;
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else if (quo_ovf) begin
          quo_d = '0;
          rmd_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b1;
        end else begin
          quo_d = neg_quo    ? -dvd_q[width-1:0] : dvd_q[width-1:0];
          rmd_d = sign_dvd_q ? -rem_q[width-1:0] : rem_q[width-1:0];
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
      zero_q     <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sign_dvd_q <= sign_dvd_d;
      sign_dvs_q <= sign_dvs_d;
      zero_q     <= zero_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (width=6): results, flags, latency, handshake and reset abort.
module tb_div_seq;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int busy_cnt;
  int seen_done;

  always #5 clk = ~clk;

  div_seq #(.width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] s6(input int v);
    logic [31:0] t;
    t = v;
    return {26'b0, t[5:0]};
  endfunction

  function automatic logic [2*W-1:0] s12(input int v);
    logic [31:0] t;
    t = v;
    return t[2*W-1:0];
  endfunction

  // Count edges after the accept edge until done, sampling #1 after each edge.
  task automatic wait_done();
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input int a, input int b);
    @(negedge clk);
    start    = 1'b1;
    dividend = s12(a);
    divisor  = s6(b)[W-1:0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_done();
  endtask

  task automatic check_res(input string tag, input int eq, input int er,
                           input logic ov, input logic dz);
    check({tag, "_lat"}, lat, 13);
    check({tag, "_q"}, {26'b0, quotient}, s6(eq));
    check({tag, "_r"}, {26'b0, remainder}, s6(er));
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ov});
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, dz});
  endtask

  initial begin
    #12;
    check("rst_q", {26'b0, quotient}, 0);
    check("rst_r", {26'b0, remainder}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_flags", {30'b0, overflow, div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(100, 7);
    check_res("basic", 14, 2, 1'b0, 1'b0);
    check("basic_busy_cycles", busy_cnt, 13);
    check("basic_busy_in_done", {31'b0, busy}, 0);
    @(posedge clk);
    #1;
    check("basic_done_pulse", {31'b0, done}, 0);
    check("basic_q_hold", {26'b0, quotient}, 14);

    do_op(-100, 7);   check_res("neg_dvd", -14, -2, 1'b0, 1'b0);
    do_op(100, -7);   check_res("neg_dvs", -14, 2, 1'b0, 1'b0);
    do_op(-100, -7);  check_res("neg_both", 14, -2, 1'b0, 1'b0);
    do_op(1024, -32); check_res("min_quo", -32, 0, 1'b0, 1'b0);
    do_op(992, -32);  check_res("q_m31", -31, 0, 1'b0, 1'b0);
    do_op(62, 2);     check_res("max_pos", 31, 0, 1'b0, 1'b0);
    do_op(64, 2);     check_res("ovf_pos32", 0, 0, 1'b1, 1'b0);
    do_op(-1024, -32); check_res("ovf_n1024", 0, 0, 1'b1, 1'b0);
    do_op(1000, 3);   check_res("ovf_1000", 0, 0, 1'b1, 1'b0);
    do_op(-2048, -32); check_res("ovf_2048_32", 0, 0, 1'b1, 1'b0);
    do_op(-2048, -1); check_res("ovf_2048_1", 0, 0, 1'b1, 1'b0);
    do_op(5, 0);      check_res("dbz", 0, 0, 1'b0, 1'b1);
    do_op(20, 4);     check_res("after_dbz", 5, 0, 1'b0, 1'b0);

    // A start pulse mid-calculation must not disturb the running operation.
    @(negedge clk);
    start = 1'b1; dividend = s12(100); divisor = 6'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = s12(50); divisor = 6'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_res("ign_start", 14, 2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("ign_start_idle", {31'b0, busy}, 0);

    // Start held high through the done cycle: second op is accepted back-to-back.
    @(negedge clk);
    start = 1'b1; dividend = s12(100); divisor = 6'd7;
    @(posedge clk);
    #1;
    dividend = s12(-100); divisor = s6(-7)[W-1:0];
    wait_done();
    check_res("b2b_first", 14, 2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy2", {31'b0, busy}, 1);
    wait_done();
    check("b2b_gap", lat + 1, 14);
    check("b2b_q2", {26'b0, quotient}, s6(14));
    check("b2b_r2", {26'b0, remainder}, s6(-2));

    // Asynchronous reset between edges aborts the operation silently.
    @(negedge clk);
    start = 1'b1; dividend = s12(100); divisor = 6'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_q", {26'b0, quotient}, 0);
    check("arst_r", {26'b0, remainder}, 0);
    check("arst_flags", {30'b0, overflow, div_by_zero}, 0);
    seen_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("arst_no_done", seen_done, 0);
    do_op(63, 9);
    check_res("post_rst", 7, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
